// File: rtl/aes_ctrl_sequencer_if.sv
// Control-chain handshake bundle between the AES sequencer and its host/consumer.
// The master modport is the sequencer side; the slave modport is the host side.
interface aes_ctrl_sequencer_if #(
    parameter int NROUNDS = 10
);
    localparam int RW = $clog2(NROUNDS + 1);

    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          load_en;
    logic          step_en;
    logic [RW-1:0] round_idx;
    logic          last_round;
    logic          busy;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  in_valid,
        input  flush,
        input  out_ready,
        output in_ready,
        output load_en,
        output step_en,
        output round_idx,
        output last_round,
        output busy,
        output out_valid
    );

    modport slave (
        output in_valid,
        output flush,
        output out_ready,
        input  in_ready,
        input  load_en,
        input  step_en,
        input  round_idx,
        input  last_round,
        input  busy,
        input  out_valid
    );
endinterface

// File: rtl/aes_ctrl_sequencer.sv
// Driver of the AES control-propagation chains: one load strobe, NROUNDS rounds of
// LAT cycles each with a step strobe on the last cycle, then a backpressured done.
module aes_ctrl_sequencer #(
    parameter int NROUNDS = 10,
    parameter int LAT     = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    aes_ctrl_sequencer_if.master bus
);
    localparam int RW = $clog2(NROUNDS + 1);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [RW-1:0] LAST_RND = RW'(NROUNDS - 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [RW-1:0] r_round_cnt;
    logic [RW-1:0] w_round_nxt;
    logic [CW-1:0] r_cycle_cnt;
    logic [CW-1:0] w_cycle_nxt;

    logic          r_load_en;
    logic          r_step_en;
    logic          r_last_round;
    logic [RW-1:0] r_round_idx;
    logic          r_busy;
    logic          r_out_valid;

    // Flush overrides every transition; DONE accepts a new start when the result drains.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round_cnt;
        w_cycle_nxt = r_cycle_cnt;
        if (bus.flush) begin
            w_state_nxt = IDLE;
            w_round_nxt = '0;
            w_cycle_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_state_nxt = LOAD;
                        w_round_nxt = '0;
                        w_cycle_nxt = '0;
                    end
                end
                LOAD: begin
                    w_state_nxt = ROUND;
                    w_round_nxt = '0;
                    w_cycle_nxt = '0;
                end
                ROUND: begin
                    if (r_cycle_cnt == LAST_CYC) begin
                        w_cycle_nxt = '0;
                        if (r_round_cnt == LAST_RND) begin
                            w_state_nxt = DONE;
                            w_round_nxt = '0;
                        end else begin
                            w_round_nxt = r_round_cnt + RW'(1);
                        end
                    end else begin
                        w_cycle_nxt = r_cycle_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        w_state_nxt = bus.in_valid ? LOAD : IDLE;
                        w_round_nxt = '0;
                        w_cycle_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_round_nxt = '0;
                    w_cycle_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_round_cnt  <= '0;
            r_cycle_cnt  <= '0;
            r_load_en    <= 1'b0;
            r_step_en    <= 1'b0;
            r_last_round <= 1'b0;
            r_round_idx  <= '0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_round_cnt  <= w_round_nxt;
            r_cycle_cnt  <= w_cycle_nxt;
            r_load_en    <= (w_state_nxt == LOAD);
            r_step_en    <= (w_state_nxt == ROUND) && (w_cycle_nxt == LAST_CYC);
            r_last_round <= (w_state_nxt == ROUND) && (w_round_nxt == LAST_RND);
            r_round_idx  <= (w_state_nxt == ROUND) ? w_round_nxt : '0;
            r_busy       <= (w_state_nxt == LOAD) || (w_state_nxt == ROUND);
            r_out_valid  <= (w_state_nxt == DONE);
        end
    end

    // in_ready follows out_ready in DONE so a drained result can overlap the next start.
    assign bus.in_ready   = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
    assign bus.load_en    = r_load_en;
    assign bus.step_en    = r_step_en;
    assign bus.last_round = r_last_round;
    assign bus.round_idx  = r_round_idx;
    assign bus.busy       = r_busy;
    assign bus.out_valid  = r_out_valid;
endmodule

// File: tb/tb_aes_ctrl_sequencer.sv
// Self-checking bench: default sequencer (10 rounds x 4 cycles) plus a 1x1 corner instance.
// Completion timing is tracked by a scoreboard of expected out_valid rise cycles.
module tb_aes_ctrl_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   sbQ[$];
    logic prevOv;

    aes_ctrl_sequencer_if #(.NROUNDS(10)) dIf ();
    aes_ctrl_sequencer_if #(.NROUNDS(1))  cIf ();

    aes_ctrl_sequencer #(.NROUNDS(10), .LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dIf.master)
    );

    aes_ctrl_sequencer #(.NROUNDS(1), .LAT(1)) dutCorner (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cIf.master)
    );

    typedef struct {
        logic     iv;
        logic     ordy;
        logic     exIr;
        logic     exLoad;
        logic     exStep;
        logic     exLast;
        int       exRound;
        logic     exBusy;
        logic     exOv;
    } vec_t;

    vec_t vecs[46];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkAll(input string name, input logic ir, input logic ld, input logic st,
                            input logic lr, input int rnd, input logic bs, input logic ov);
        checkOutput({name, ".in_ready"},   int'(dIf.in_ready),   int'(ir));
        checkOutput({name, ".load_en"},    int'(dIf.load_en),    int'(ld));
        checkOutput({name, ".step_en"},    int'(dIf.step_en),    int'(st));
        checkOutput({name, ".last_round"}, int'(dIf.last_round), int'(lr));
        checkOutput({name, ".round_idx"},  int'(dIf.round_idx),  rnd);
        checkOutput({name, ".busy"},       int'(dIf.busy),       int'(bs));
        checkOutput({name, ".out_valid"},  int'(dIf.out_valid),  int'(ov));
    endtask

    // Drive one cycle's inputs just after the rising edge and return at the falling edge.
    task automatic applyStimulus(input logic iv, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        dIf.in_valid  = iv;
        dIf.out_ready = ordy;
        dIf.flush     = fl;
        @(negedge clk);
    endtask

    task automatic runToDone(input int limit, input logic ordy, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            applyStimulus(1'b0, ordy, 1'b0);
            if (dIf.out_valid) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            checkOutput("done_timeout", 0, 1);
        end
    endtask

    // Scoreboard: every rising out_valid must match the oldest expected completion cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevOv = 1'b0;
        end else begin
            if (dIf.out_valid && !prevOv) begin
                if (sbQ.size() == 0) begin
                    checkOutput("sb_unexpected_out_valid", 1, 0);
                end else begin
                    checkOutput("sb_latency", cyc, sbQ.pop_front());
                end
            end
            prevOv = dIf.out_valid;
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        cyc    = 0;
        prevOv = 1'b0;
        rst_n  = 1'b0;
        dIf.in_valid  = 1'b0;
        dIf.out_ready = 1'b1;
        dIf.flush     = 1'b0;
        cIf.in_valid  = 1'b0;
        cIf.out_ready = 1'b1;
        cIf.flush     = 1'b0;

        for (int i = 0; i < 46; i++) begin
            vecs[i].iv      = (i == 0);
            vecs[i].ordy    = 1'b1;
            vecs[i].exIr    = (i == 0) || (i >= 42);
            vecs[i].exLoad  = (i == 1);
            vecs[i].exStep  = (i >= 2) && (i <= 41) && (((i - 2) % 4) == 3);
            vecs[i].exLast  = (i >= 38) && (i <= 41);
            vecs[i].exRound = ((i >= 2) && (i <= 41)) ? (i - 2) / 4 : 0;
            vecs[i].exBusy  = (i >= 1) && (i <= 41);
            vecs[i].exOv    = (i == 42);
        end

        $display("[TB] reset and defaults");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkAll("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 46; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].ordy, 1'b0);
            if (vecs[i].iv) sbQ.push_back(cyc + 42);
            checkAll($sformatf("seq[%0d]", i), vecs[i].exIr, vecs[i].exLoad, vecs[i].exStep,
                     vecs[i].exLast, vecs[i].exRound, vecs[i].exBusy, vecs[i].exOv);
        end

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, 1'b0);
        sbQ.push_back(cyc + 42);
        checkOutput("bp.accept_ready", int'(dIf.in_ready), 1);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus((k == 10) || (k == 20), 1'b0, 1'b0);
            if (k == 10) checkOutput("bp.busy_in_ready", int'(dIf.in_ready), 0);
            if (dIf.out_valid) begin
                n = k;
                break;
            end
        end
        checkOutput("bp.latency", n, 42);
        for (int j = 1; j <= 6; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("bp.hold_ov[%0d]", j), int'(dIf.out_valid), 1);
            checkOutput($sformatf("bp.hold_ir[%0d]", j), int'(dIf.in_ready), 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("bp.drain", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkAll($sformatf("bp.idle[%0d]", j), 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 1'b1, 1'b0);
        sbQ.push_back(cyc + 42);
        for (int k = 1; k <= 41; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        sbQ.push_back(cyc + 42);
        checkAll("b2b.done", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("b2b.load", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("b2b.round0", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        runToDone(60, 1'b1, n);
        checkOutput("b2b.latency", n + 2, 42);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] flush mid-round");
        applyStimulus(1'b1, 1'b1, 1'b0);
        sbQ.push_back(cyc + 42);
        for (int k = 1; k <= 23; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        void'(sbQ.pop_back());
        checkAll("flush.cycle", 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("flush.after", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        sbQ.push_back(cyc + 42);
        runToDone(60, 1'b1, n);
        checkOutput("flush.restart_latency", n, 42);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] async reset in round 3");
        applyStimulus(1'b1, 1'b1, 1'b0);
        sbQ.push_back(cyc + 42);
        for (int k = 1; k <= 15; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("areset.pre_round", int'(dIf.round_idx), 3);
        #2;
        rst_n = 1'b0;
        dIf.in_valid = 1'b1;
        void'(sbQ.pop_back());
        #1;
        checkAll("areset.immediate", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checkAll($sformatf("areset.held[%0d]", j), 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end
        dIf.in_valid = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkAll("areset.release", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] corner NROUNDS=1 LAT=1");
        @(posedge clk);
        #1;
        cIf.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("corner.accept_ready", int'(cIf.in_ready), 1);
        @(posedge clk);
        #1;
        cIf.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("corner.load", int'(cIf.load_en), 1);
        checkOutput("corner.load_busy", int'(cIf.busy), 1);
        @(negedge clk);
        checkOutput("corner.step", int'(cIf.step_en), 1);
        checkOutput("corner.last", int'(cIf.last_round), 1);
        checkOutput("corner.round", int'(cIf.round_idx), 0);
        checkOutput("corner.step_ov", int'(cIf.out_valid), 0);
        @(negedge clk);
        checkOutput("corner.ov", int'(cIf.out_valid), 1);
        checkOutput("corner.ov_step", int'(cIf.step_en), 0);
        checkOutput("corner.ov_busy", int'(cIf.busy), 0);
        @(negedge clk);
        checkOutput("corner.idle_ov", int'(cIf.out_valid), 0);
        checkOutput("corner.idle_ir", int'(cIf.in_ready), 1);

        checkOutput("sb.empty", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
